// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : RV32I operand fetch stage. Holds the 32x32 integer register file,
//            reads rs1/rs2 for each accepted instruction and presents a
//            registered operand bundle to the ALU through a one-entry
//            valid/ready output buffer. Writebacks on the same edge are
//            forwarded into the captured operands. A held entry is kept
//            coherent with later writebacks.
// Ports    : clk             - single clock, rising edge
//            reset_n         - asynchronous active-low reset
//            in_valid        - upstream presents in_instruction
//            in_ready        - stage can accept in_instruction this cycle
//            in_instruction  - RV32I instruction word (opcode in [6:0])
//            out_valid       - out_* hold a valid operand bundle
//            out_ready       - ALU consumes the bundle this cycle
//            out_instruction - instruction for the ALU
//            out_op_a        - value of rs1 (instruction[19:15])
//            out_op_b        - value of rs2 (instruction[24:20])
//            wb_en/wb_rd/wb_data - register file writeback port
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int unsigned REGFILE_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    // addi x0,x0,0 -- the canonical NOP shown while nothing has been accepted
    localparam logic [31:0] c_nop = 32'h0000_0013;

    // Entry 0 is never written; reads of x0 are forced to zero by the muxes.
    logic [31:0] r_regs [0:31];

    logic        r_out_valid;
    logic [31:0] r_out_instruction;
    logic [31:0] r_out_op_a;
    logic [31:0] r_out_op_b;

    logic        w_accept;
    logic        w_hold;
    logic        w_wb_hit;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_held_rs1;
    logic [4:0]  w_held_rs2;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1      = in_instruction[19:15];
    assign w_rs2      = in_instruction[24:20];
    assign w_held_rs1 = r_out_instruction[19:15];
    assign w_held_rs2 = r_out_instruction[24:20];

    // A write to x0 is architecturally a no-op, so it never counts as a hit.
    assign w_wb_hit = wb_en && (wb_rd != 5'd0);

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_hold   = r_out_valid && !out_ready;

    // Same-edge forwarding: the register file write lands on the same edge
    // as the capture, so the incoming writeback data must win over the
    // stale array value.
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        if (w_rs1 == 5'd0) begin
            w_rs1_val = 32'h0000_0000;
        end else if (w_wb_hit && (wb_rd == w_rs1)) begin
            w_rs1_val = wb_data;
        end
    end

    always_comb begin
        w_rs2_val = r_regs[w_rs2];
        if (w_rs2 == 5'd0) begin
            w_rs2_val = 32'h0000_0000;
        end else if (w_wb_hit && (wb_rd == w_rs2)) begin
            w_rs2_val = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    generate
        if (REGFILE_CLEAR != 0) begin : g_regfile_clear
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < 32; i++) begin
                        r_regs[i] <= 32'h0000_0000;
                    end
                end else if (w_wb_hit) begin
                    r_regs[wb_rd] <= wb_data;
                end
            end
        end else begin : g_regfile_noclear
            // Contents survive reset, but a writeback presented while reset
            // is asserted is still dropped.
            always_ff @(posedge clk) begin
                if (reset_n && w_wb_hit) begin
                    r_regs[wb_rd] <= wb_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // One-entry output buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid       <= 1'b0;
            r_out_instruction <= c_nop;
            r_out_op_a        <= 32'h0000_0000;
            r_out_op_b        <= 32'h0000_0000;
        end else if (w_accept) begin
            r_out_valid       <= 1'b1;
            r_out_instruction <= in_instruction;
            r_out_op_a        <= w_rs1_val;
            r_out_op_b        <= w_rs2_val;
        end else if (w_hold) begin
            // Stalled bundle tracks later writes to its source registers so
            // it never presents a value older than the register file.
            if (w_wb_hit && (wb_rd == w_held_rs1)) begin
                r_out_op_a <= wb_data;
            end
            if (w_wb_hit && (wb_rd == w_held_rs2)) begin
                r_out_op_b <= wb_data;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid       = r_out_valid;
    assign out_instruction = r_out_instruction;
    assign out_op_a        = r_out_op_a;
    assign out_op_b        = r_out_op_b;

endmodule
`default_nettype wire
